// File: rtl/uc_seq.sv
// uc_seq -- microcoded-CPU control sequencer with debug run/step control.
//
// Decodes the 6-bit instruction opcode into datapath enables during execute
// cycles (states RUN and STEP). The enables are a zero-latency decode: they
// are valid in the same cycle the opcode is presented. Free-running execution
// starts on a rising edge of run. A rising edge of step executes exactly one
// instruction. An illegal opcode traps the sequencer in ERR until reset.
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   Opcode   in   [5:0] instruction bits [15:10]
//   z        in   registered zero flag from the datapath
//   run      in   debug run request (edge-triggered start, level keeps running)
//   step     in   debug single-step request (edge-triggered)
//   s_inc    out  PC source: 1 = PC+1, 0 = jump target
//   s_inm    out  register write data: 1 = immediate, 0 = ALU result
//   we3      out  register file write enable
//   wez      out  zero flag write enable
//   Op       out  [2:0] ALU operation select
//   pc_en    out  PC load enable
//   halted   out  1 while not executing (IDLE or ERR)
//   illegal  out  sticky illegal-opcode flag
//   icount   out  [15:0] retired-instruction counter (wraps)
module uc_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Opcode,
  input  logic        z,
  input  logic        run,
  input  logic        step,
  output logic        s_inc,
  output logic        s_inm,
  output logic        we3,
  output logic        wez,
  output logic [2:0]  Op,
  output logic        pc_en,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] icount
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    ERR  = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic run_q, step_q;
  logic run_edge, step_edge;
  logic exec;
  logic is_alu, is_li, is_j, is_jz, is_jnz, is_halt, is_illegal;
  logic retire;

  assign run_edge  = run  & ~run_q;
  assign step_edge = step & ~step_q;
  assign exec      = (state_q == RUN) || (state_q == STEP);

  // Opcode classes. Everything with bit 5 set and either bit 4 or bit 3 set
  // (101--- and 11----) is unassigned.
  assign is_alu     = ~Opcode[5];
  assign is_li      = (Opcode[5:2] == 4'b1000);
  assign is_j       = (Opcode == 6'b100100);
  assign is_jz      = (Opcode == 6'b100101);
  assign is_jnz     = (Opcode == 6'b100110);
  assign is_halt    = (Opcode == 6'b100111);
  assign is_illegal = Opcode[5] & (Opcode[4] | Opcode[3]);

  // Jumps (taken or not) count as retired; HALT and illegal opcodes do not.
  assign retire = exec & ~is_illegal & ~is_halt;

  // Only the registered state feeds halted, so it never glitches with Opcode.
  assign halted = (state_q == IDLE) || (state_q == ERR);

  always_comb begin
    s_inc = 1'b1;
    s_inm = 1'b0;
    we3   = 1'b0;
    wez   = 1'b0;
    Op    = 3'b000;
    pc_en = 1'b0;
    if (exec) begin
      if (is_alu) begin
        Op    = Opcode[4:2];
        we3   = 1'b1;
        wez   = 1'b1;
        pc_en = 1'b1;
      end else if (is_li) begin
        s_inm = 1'b1;
        we3   = 1'b1;
        pc_en = 1'b1;
      end else if (is_j) begin
        s_inc = 1'b0;
        pc_en = 1'b1;
      end else if (is_jz) begin
        s_inc = ~z;
        pc_en = 1'b1;
      end else if (is_jnz) begin
        s_inc = z;
        pc_en = 1'b1;
      end
      // HALT and illegal opcodes leave every enable low.
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        // run wins over a simultaneous step edge.
        if (run_edge)       state_d = RUN;
        else if (step_edge) state_d = STEP;
      end
      RUN: begin
        // The instruction in flight still executes before leaving RUN.
        if (is_illegal)   state_d = ERR;
        else if (is_halt) state_d = IDLE;
        else if (!run)    state_d = IDLE;
      end
      STEP: begin
        if (is_illegal) state_d = ERR;
        else            state_d = IDLE;
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // History registers reset to 1 so a level held through reset release is
  // not mistaken for a fresh request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      run_q   <= 1'b1;
      step_q  <= 1'b1;
      illegal <= 1'b0;
      icount  <= 16'h0000;
    end else begin
      state_q <= state_d;
      run_q   <= run;
      step_q  <= step;
      if (exec && is_illegal) illegal <= 1'b1;
      if (retire)             icount  <= icount + 16'd1;
    end
  end

endmodule

// File: tb/tb_uc_seq.sv
// Testbench for uc_seq: directed scenarios plus a randomized run checked
// against a behavioural model of the sequencer.
module tb_uc_seq;

  logic        clk;
  logic        reset;
  logic [5:0]  Opcode;
  logic        z;
  logic        run;
  logic        step;
  logic        s_inc, s_inm, we3, wez, pc_en, halted, illegal;
  logic [2:0]  Op;
  logic [15:0] icount;

  int checks   = 0;
  int failures = 0;

  uc_seq dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .run(run), .step(step),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
    .pc_en(pc_en), .halted(halted), .illegal(illegal), .icount(icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  wire [8:0] ctl = {s_inc, s_inm, we3, wez, Op, pc_en, halted};

  // Reference model
  localparam int MI = 0, MR = 1, MS = 2, ME = 3;
  localparam int K_ALU = 0, K_LI = 1, K_J = 2, K_JZ = 3, K_JNZ = 4, K_HALT = 5, K_ILL = 6;
  localparam logic [8:0] CTL_IDLE = 9'b1_0_0_0_000_0_1;

  int          m_mode;
  logic        m_prev_run, m_prev_step, m_illegal;
  logic [15:0] m_icount;

  function automatic int kind_of(input logic [5:0] op);
    int v;
    v = int'(op);
    if (v < 32)  return K_ALU;
    if (v < 36)  return K_LI;
    if (v == 36) return K_J;
    if (v == 37) return K_JZ;
    if (v == 38) return K_JNZ;
    if (v == 39) return K_HALT;
    return K_ILL;
  endfunction

  function automatic logic [8:0] exp_ctl(input int mode, input logic [5:0] op, input logic zf);
    logic si, sm, w, wz, pe, h;
    logic [2:0] o;
    si = 1; sm = 0; w = 0; wz = 0; pe = 0; h = 1; o = 3'd0;
    if (mode == MR || mode == MS) begin
      h = 0;
      case (kind_of(op))
        K_ALU: begin o = 3'((int'(op) / 4) % 8); w = 1; wz = 1; pe = 1; end
        K_LI:  begin sm = 1; w = 1; pe = 1; end
        K_J:   begin si = 0; pe = 1; end
        K_JZ:  begin si = !zf; pe = 1; end
        K_JNZ: begin si = zf; pe = 1; end
        default: ;
      endcase
    end
    return {si, sm, w, wz, o, pe, h};
  endfunction

  task automatic m_reset();
    m_mode = MI; m_prev_run = 1; m_prev_step = 1; m_illegal = 0; m_icount = 16'h0000;
  endtask

  task automatic m_update();
    bit re, se;
    int k;
    if (!reset) begin m_reset(); return; end
    re = run && !m_prev_run;
    se = step && !m_prev_step;
    k  = kind_of(Opcode);
    if (m_mode == MR || m_mode == MS) begin
      if (k == K_ILL) m_illegal = 1;
      else if (k != K_HALT) m_icount = m_icount + 16'd1;
    end
    case (m_mode)
      MI: m_mode = re ? MR : (se ? MS : MI);
      MR: m_mode = (k == K_ILL) ? ME : ((k == K_HALT || !run) ? MI : MR);
      MS: m_mode = (k == K_ILL) ? ME : MI;
      default: m_mode = ME;
    endcase
    m_prev_run = run; m_prev_step = step;
  endtask

  // Advance one clock; model follows the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    m_reset();
    #1;
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0; run = 1; step = 1; Opcode = 6'b000100; z = 0;
    m_reset();
    @(negedge clk); #1;
    checks++; if (ctl !== CTL_IDLE) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_IDLE); end
    checks++; if (icount !== 16'h0000) begin failures++; $display("FAIL reset_icount got=%h exp=0000", icount); end
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    reset = 1;
    tick(); tick();
    #1;
    checks++; if (ctl !== CTL_IDLE) begin failures++; $display("FAIL held_level_no_start got=%b exp=%b", ctl, CTL_IDLE); end
    checks++; if (icount !== 16'h0000) begin failures++; $display("FAIL held_level_icount got=%h exp=0000", icount); end
  endtask

  task automatic test_run_alu();
    do_reset();
    run = 0; step = 0; Opcode = 6'b000100; z = 0;
    tick();
    run = 1; tick();
    run = 0; #1;
    checks++; if (ctl !== 9'b1_0_1_1_001_1_0) begin failures++; $display("FAIL run_alu_ctl got=%b exp=%b", ctl, 9'b1_0_1_1_001_1_0); end
    tick(); #1;
    checks++; if (icount !== 16'd1) begin failures++; $display("FAIL run_alu_icount got=%h exp=0001", icount); end
    checks++; if (ctl !== CTL_IDLE) begin failures++; $display("FAIL run_alu_back_idle got=%b exp=%b", ctl, CTL_IDLE); end
  endtask

  task automatic test_step_li();
    do_reset();
    run = 0; step = 0; Opcode = 6'b100000; z = 0;
    tick();
    step = 1; tick();
    step = 0; #1;
    checks++; if (ctl !== 9'b1_1_1_0_000_1_0) begin failures++; $display("FAIL step_li_ctl got=%b exp=%b", ctl, 9'b1_1_1_0_000_1_0); end
    tick(); #1;
    checks++; if (ctl !== CTL_IDLE) begin failures++; $display("FAIL step_li_idle got=%b exp=%b", ctl, CTL_IDLE); end
    checks++; if (icount !== 16'd1) begin failures++; $display("FAIL step_li_icount got=%h exp=0001", icount); end
    tick(); #1;
    checks++; if (ctl !== CTL_IDLE) begin failures++; $display("FAIL step_li_stays_idle got=%b exp=%b", ctl, CTL_IDLE); end
  endtask

  task automatic test_jumps();
    logic [5:0] ops [4];
    logic       zs  [4];
    logic       exp_si [4];
    ops = '{6'b100101, 6'b100110, 6'b100101, 6'b100110};
    zs  = '{1'b1, 1'b1, 1'b0, 1'b0};
    exp_si = '{1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    run = 0; step = 0; Opcode = 6'b000000; z = 0;
    tick();
    run = 1; tick();
    for (int i = 0; i < 4; i++) begin
      Opcode = ops[i]; z = zs[i]; #1;
      checks++;
      if (s_inc !== exp_si[i] || pc_en !== 1'b1 || we3 !== 1'b0 || wez !== 1'b0) begin
        failures++;
        $display("FAIL jump_%0d got s_inc=%b pc_en=%b we3=%b wez=%b exp s_inc=%b pc_en=1 we3=0 wez=0",
                 i, s_inc, pc_en, we3, wez, exp_si[i]);
      end
      tick();
    end
    #1;
    checks++; if (icount !== 16'd4) begin failures++; $display("FAIL jumps_icount got=%h exp=0004", icount); end
    run = 0; Opcode = 6'b000000;
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    run = 0; step = 0; Opcode = 6'b000000; z = 0;
    tick();
    run = 1; tick();
    Opcode = 6'b110000; #1;
    checks++;
    if (pc_en !== 1'b0 || we3 !== 1'b0 || wez !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL illegal_cycle got pc_en=%b we3=%b wez=%b halted=%b exp 0 0 0 0", pc_en, we3, wez, halted);
    end
    tick(); #1;
    checks++; if (illegal !== 1'b1 || halted !== 1'b1) begin failures++; $display("FAIL illegal_err got illegal=%b halted=%b exp 1 1", illegal, halted); end
    Opcode = 6'b000100; run = 0; step = 0; tick();
    run = 1; step = 1; tick(); #1;
    checks++; if (ctl !== CTL_IDLE || illegal !== 1'b1) begin failures++; $display("FAIL err_sticky got ctl=%b illegal=%b exp ctl=%b illegal=1", ctl, illegal, CTL_IDLE); end
    checks++; if (icount !== 16'd0) begin failures++; $display("FAIL err_icount got=%h exp=0000", icount); end
    run = 0; step = 0;
    do_reset(); #1;
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL illegal_cleared got=%b exp=0", illegal); end
  endtask

  task automatic test_halt();
    do_reset();
    run = 0; step = 0; Opcode = 6'b000000; z = 0;
    tick();
    run = 1; tick();
    tick();
    Opcode = 6'b100111; #1;
    checks++; if (pc_en !== 1'b0 || we3 !== 1'b0) begin failures++; $display("FAIL halt_cycle got pc_en=%b we3=%b exp 0 0", pc_en, we3); end
    tick();
    Opcode = 6'b000000; #1;
    checks++; if (halted !== 1'b1 || icount !== 16'd1) begin failures++; $display("FAIL halt_idle got halted=%b icount=%h exp 1 0001", halted, icount); end
    tick(); tick(); #1;
    checks++; if (halted !== 1'b1 || icount !== 16'd1) begin failures++; $display("FAIL halt_no_restart got halted=%b icount=%h exp 1 0001", halted, icount); end
    run = 0; tick();
    run = 1; tick(); #1;
    checks++; if (halted !== 1'b0 || pc_en !== 1'b1) begin failures++; $display("FAIL halt_restart got halted=%b pc_en=%b exp 0 1", halted, pc_en); end
    run = 0; tick();
  endtask

  task automatic test_random();
    int err_cycles;
    logic [8:0] e;
    do_reset();
    run = 0; step = 0; Opcode = 6'b000000; z = 0;
    err_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_mode == ME) err_cycles++;
      if (err_cycles > 8) begin
        do_reset();
        err_cycles = 0;
      end
      if ($urandom_range(0, 99) < 3) Opcode = 6'($urandom_range(40, 63));
      else                           Opcode = 6'($urandom_range(0, 39));
      z    = 1'($urandom_range(0, 1));
      run  = ($urandom_range(0, 4) != 0);
      step = ($urandom_range(0, 3) == 0);
      #1;
      e = exp_ctl(m_mode, Opcode, z);
      checks++; if (ctl !== e) begin failures++; $display("FAIL rand_ctl cyc=%0d op=%b got=%b exp=%b", i, Opcode, ctl, e); end
      checks++; if (icount !== m_icount) begin failures++; $display("FAIL rand_icount cyc=%0d got=%h exp=%h", i, icount, m_icount); end
      checks++; if (illegal !== m_illegal) begin failures++; $display("FAIL rand_illegal cyc=%0d got=%b exp=%b", i, illegal, m_illegal); end
      tick();
    end
  endtask

  task automatic test_wrap_and_async_reset();
    do_reset();
    run = 0; step = 0; Opcode = 6'b001000; z = 0;
    tick();
    run = 1; tick();
    repeat (65535) tick();
    #1;
    checks++; if (icount !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=ffff", icount); end
    tick(); #1;
    checks++; if (icount !== 16'h0000) begin failures++; $display("FAIL wrap_rollover got=%h exp=0000", icount); end
    checks++; if (pc_en !== 1'b1 || we3 !== 1'b1 || wez !== 1'b1) begin failures++; $display("FAIL pre_reset_enables got pc_en=%b we3=%b wez=%b exp 1 1 1", pc_en, we3, wez); end
    reset = 0;
    m_reset();
    #1;
    checks++; if (pc_en !== 1'b0 || we3 !== 1'b0 || wez !== 1'b0) begin failures++; $display("FAIL async_reset_enables got pc_en=%b we3=%b wez=%b exp 0 0 0", pc_en, we3, wez); end
    run = 0;
    #1;
    reset = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_run_alu();
    test_step_li();
    test_jumps();
    test_illegal();
    test_halt();
    test_random();
    test_wrap_and_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uc_seq.md
UC_SEQ -- requirements
Module: uc_seq

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; reset=0 forces reset state immediately, independent of clk.
REQ-003 Opcode  input  6  instruction bits [15:10] from the datapath; valid and stable for the whole cycle.
REQ-004 z  input  1  registered zero flag from the datapath.
REQ-005 run  input  1  debug run request; rising edge starts free execution.
REQ-006 step  input  1  debug single-step request; rising edge executes exactly one instruction.
REQ-007 s_inc  output  1  PC source: 1 = PC+1, 0 = jump target opcode[9:0].
REQ-008 s_inm  output  1  register write data: 1 = immediate opcode[11:4], 0 = ALU result.
REQ-009 we3  output  1  register file write enable.
REQ-010 wez  output  1  zero flag write enable.
REQ-011 Op  output  3  ALU operation select.
REQ-012 pc_en  output  1  PC load enable; 0 freezes PC.
REQ-013 halted  output  1  1 when not executing (IDLE or ERR).
REQ-014 illegal  output  1  sticky illegal-opcode flag.
REQ-015 icount  output  16  retired-instruction counter.

Function
REQ-016 States SHALL be IDLE, RUN, STEP, ERR; the state register SHALL be encoded in 2 bits.
REQ-017 Edge detectors SHALL register run and step each cycle; an edge is current=1 and previous=0.
REQ-018 IDLE: run edge -> RUN; else step edge -> STEP; else stay; simultaneous run and step edges -> RUN.
REQ-019 RUN: run=0 sampled -> IDLE at the next edge; the current cycle's instruction still executes; step edges ignored.
REQ-020 STEP: executes one instruction this cycle, then -> IDLE unconditionally.
REQ-021 ERR: stays in ERR until reset; run and step ignored.
REQ-022 Execute cycle (state RUN or STEP) decode, combinational from Opcode and z:
 - 0ooo-- ALU: Op=ooo, s_inm=0, we3=1, wez=1, s_inc=1, pc_en=1.
 - 1000-- LI: s_inm=1, we3=1, wez=0, s_inc=1, pc_en=1, Op=000.
 - 100100 J: s_inc=0, pc_en=1, no writes.
 - 100101 JZ: s_inc=~z, pc_en=1, no writes.
 - 100110 JNZ: s_inc=z, pc_en=1, no writes.
 - 100111 HALT: pc_en=0, no writes; next state IDLE.
 - 101--- and 11----: illegal; pc_en=0, no writes; next state ERR; illegal set at the next edge.
REQ-023 Non-execute states (IDLE, ERR) SHALL drive pc_en=0, we3=0, wez=0, s_inc=1, s_inm=0, Op=000.
REQ-024 halted SHALL be 1 in IDLE and ERR and 0 in RUN and STEP, decoded from the registered state (no combinational dependence on Opcode).
REQ-025 icount SHALL increment by 1 at the end of each execute cycle with a legal, non-HALT opcode, including jumps not taken, and wrap 0xFFFF -> 0x0000.
REQ-026 Controller latency: zero cycles; enables are valid in the same cycle the Opcode is presented.

Reset
REQ-027 reset=0 SHALL force: state=IDLE, illegal=0, icount=0x0000, run and step history registers=1.
REQ-028 Consequently, a run or step level held high across reset release is not an edge; a new 0->1 transition is required.
REQ-029 Reset asserted mid-instruction SHALL drop pc_en, we3 and wez to 0 immediately (asynchronously).

Verification
REQ-030 Reset release, then run pulse; Opcode=000100 (ALU, Op=001) -> the cycle after the pulse: we3=1, wez=1, Op=001, pc_en=1, halted=0; icount=1 after one execute cycle.
REQ-031 In IDLE, step pulse with Opcode=100000 (LI) -> exactly one cycle with we3=1, s_inm=1, pc_en=1; then IDLE; icount +1; a further cycle shows no enables.
REQ-032 In RUN with z=1, apply JZ, then JNZ -> s_inc=0 then s_inc=1; with z=0 the values are reversed; icount increments on all four.
REQ-033 In RUN, Opcode=110000 -> that cycle pc_en=0, we3=0; next cycle state ERR, illegal=1, halted=1; run/step pulses have no effect; reset clears illegal.
REQ-034 In RUN, Opcode=100111 -> pc_en=0, next state IDLE, icount unchanged; run held high does not restart; run toggled 0->1 restarts execution.
REQ-035 Preload icount=0xFFFF via 65535 ALU cycles, then execute one more -> icount=0x0000; assert reset mid-run -> enables drop to 0 before the next clock edge.
